// File: rtl/status_vector_drain.sv
// Drains single-bit status entries from an upstream vector and packs them LSB-first
// into words handed to a sink over valid/ready; also counts upstream back-pressure cycles.
module status_vector_drain #(
    parameter  int WORD_W  = 8,
    parameter  int STALL_W = 16,
    localparam int CNT_W   = $clog2(WORD_W) + 1
) (
    input  logic               clk_i,
    input  logic               rsn_i,
    input  logic               enable_i,
    input  logic               flush_i,
    input  logic               valid_i,
    input  logic               value_i,
    input  logic               full_i,
    output logic               pull_o,
    output logic [WORD_W-1:0]  word_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               word_valid_o,
    input  logic               word_ready_i,
    output logic [STALL_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    state_t              state_q;
    logic [WORD_W-1:0]   word_q;
    logic [CNT_W-1:0]    count_q;
    logic [STALL_W-1:0]  stall_q;

    logic                accept;
    logic [CNT_W-1:0]    count_next;
    logic [WORD_W-1:0]   word_next;
    logic                word_full;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == {STALL_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Upstream valid is registered, so popping directly off it forms no loop.
    always_comb begin
        accept     = (state_q == COLLECT) && valid_i;
        count_next = count_q + CNT_W'(accept);
        word_next  = word_q;
        if (accept)
            word_next = word_q | (WORD_W'(value_i) << count_q);
        word_full  = (count_next == CNT_W'(WORD_W));
    end

    assign pull_o       = accept;
    assign word_o       = word_q;
    assign count_o      = count_q;
    assign word_valid_o = (state_q == OUTPUT);
    assign stall_cnt_o  = stall_q;

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= IDLE;
            word_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            if (full_i && !accept)
                stall_q <= sat_inc(stall_q);

            case (state_q)
                IDLE: begin
                    if (enable_i)
                        state_q <= COLLECT;
                end
                COLLECT: begin
                    word_q  <= word_next;
                    count_q <= count_next;
                    // A completed word wins over flush/disable; a same-cycle flush is absorbed.
                    if (accept && word_full)
                        state_q <= OUTPUT;
                    else if ((flush_i || !enable_i) && count_next != '0)
                        state_q <= OUTPUT;
                    else if (!enable_i)
                        state_q <= IDLE;
                end
                OUTPUT: begin
                    if (word_ready_i) begin
                        word_q  <= '0;
                        count_q <= '0;
                        state_q <= enable_i ? COLLECT : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
